// File: rtl/mem_loader_ram.sv
// Single-port word RAM with a post-reset fill sweep and a streaming program loader.
// CPU reads are registered (1-cycle latency, read-first); the loader and clear own the array while busy.
module mem_loader_ram #(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       ADDR_W         = 13,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] WD,
  input  logic              memorywrite,
  input  logic              memoryread,
  output logic [DATA_W-1:0] RD,
  output logic              rd_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PtrMax = '1;

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;
  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rd_q;
  logic                rd_valid_q;
  logic                load_done_q, load_done_d;
  logic                rd_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = FILL_VALUE;
    rd_en       = 1'b0;
    load_done_d = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PtrMax) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // load_start wins the cycle: CPU requests alongside it are dropped
        if (load_start) begin
          ptr_d   = load_base;
          state_d = StLoad;
        end else begin
          if (memorywrite) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = WD;
          end
          rd_en = memoryread;
        end
      end
      StLoad: begin
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          ptr_d     = ptr_q + 1'b1;
          if (load_last) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ResetState;
      ptr_q       <= '0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_valid_q  <= rd_en;
      load_done_q <= load_done_d;
      if (rd_en) begin
        rd_q <= mem[addr];
      end
    end
  end

  // Array has no reset; its contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign RD         = rd_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q != StIdle);
  assign load_ready = (state_q == StLoad);
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_mem_loader_ram.sv
// Directed bench for mem_loader_ram (DATA_W=8, ADDR_W=4): clear, CPU access, loader, reset.
module tb_mem_loader_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] WD;
  logic       memorywrite;
  logic       memoryread;
  logic [7:0] RD;
  logic       rd_valid;
  logic       busy;
  logic       load_start;
  logic [3:0] load_base;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_done;

  int total = 0;
  int bad   = 0;

  mem_loader_ram #(
    .DATA_W        (8),
    .ADDR_W        (4),
    .CLEAR_ON_RESET(1'b1),
    .FILL_VALUE    (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .WD         (WD),
    .memorywrite(memorywrite),
    .memoryread (memoryread),
    .RD         (RD),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic v);
    addr       = a;
    memoryread = 1'b1;
    step();
    d          = RD;
    v          = rd_valid;
    memoryread = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 100);
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL %s: busy cycles got %0d want 16", name, n);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    #1;
    got = {busy, RD != 8'h00, rd_valid, load_ready, load_done};
    total++;
    if (got !== 5'b10000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 10000", got);
    end
    step();
    step();
    rst = 1'b1;
    count_clear("reset_clear_len");
  endtask

  task automatic test_clear_reads();
    logic [7:0] d;
    logic       v;
    for (int a = 0; a < 16; a++) begin
      cpu_read(a[3:0], d, v);
      total++;
      if (d !== 8'h00 || v !== 1'b1) begin
        bad++;
        $display("FAIL clear_read[%0d]: got RD=%h v=%b want RD=00 v=1", a, d, v);
      end
    end
    step();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_valid_pulse: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    logic       v;
    addr = 4'h3; WD = 8'hA5; memorywrite = 1'b1;
    step();
    memorywrite = 1'b0;
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_no_valid: got %b want 0", rd_valid);
    end
    cpu_read(4'h3, d, v);
    total++;
    if (d !== 8'hA5 || v !== 1'b1) begin
      bad++;
      $display("FAIL write_read: got RD=%h v=%b want RD=a5 v=1", d, v);
    end
    step();
    total++;
    if (RD !== 8'hA5 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold: got RD=%h v=%b want RD=a5 v=0", RD, rd_valid);
    end
  endtask

  task automatic test_read_first();
    logic [7:0] d;
    logic       v;
    addr = 4'h5; WD = 8'h11; memorywrite = 1'b1;
    step();
    WD = 8'h22; memoryread = 1'b1;
    step();
    memorywrite = 1'b0; memoryread = 1'b0;
    total++;
    if (RD !== 8'h11 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL read_first_old: got RD=%h v=%b want RD=11 v=1", RD, rd_valid);
    end
    cpu_read(4'h5, d, v);
    total++;
    if (d !== 8'h22) begin
      bad++;
      $display("FAIL read_first_new: got %h want 22", d);
    end
  endtask

  task automatic test_load_wrap();
    logic [7:0] d;
    logic       v;
    logic [7:0] exp [4];
    logic [3:0] adr [4];
    exp = '{8'h01, 8'h02, 8'h03, 8'h00};
    adr = '{4'hE, 4'hF, 4'h0, 4'h7};
    // CPU requests alongside load_start must be dropped
    load_start = 1'b1; load_base = 4'hE;
    addr = 4'h7; WD = 8'hFF; memorywrite = 1'b1; memoryread = 1'b1;
    step();
    load_start = 1'b0;
    total++;
    if (busy !== 1'b1 || load_ready !== 1'b1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_enter: got busy=%b rdy=%b v=%b want 1 1 0", busy, load_ready, rd_valid);
    end
    step();
    memorywrite = 1'b0; memoryread = 1'b0;
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_read_ignored: got %b want 0", rd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = exp[i];
      load_last  = (i == 2);
      step();
    end
    load_valid = 1'b0; load_last = 1'b0;
    total++;
    if (load_done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_finish: got done=%b busy=%b rdy=%b want 1 0 0", load_done, busy,
               load_ready);
    end
    step();
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL load_done_pulse: got %b want 0", load_done);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read(adr[i], d, v);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("FAIL load_wrap_mem[%h]: got %h want %h", adr[i], d, exp[i]);
      end
    end
  endtask

  task automatic test_load_stall();
    logic [7:0] d;
    logic       v;
    logic [7:0] exp [3];
    exp = '{8'h31, 8'h32, 8'h00};
    load_start = 1'b1; load_base = 4'h8;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h31;
    step();
    load_valid = 1'b0; load_data = 8'h99;
    step();
    step();
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold: got rdy=%b busy=%b done=%b want 1 1 0", load_ready, busy,
               load_done);
    end
    load_valid = 1'b1; load_data = 8'h32; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    total++;
    if (load_done !== 1'b1) begin
      bad++;
      $display("FAIL stall_done: got %b want 1", load_done);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(4'h8 + i[3:0], d, v);
      total++;
      if (d !== exp[i]) begin
        bad++;
        $display("FAIL stall_mem[%0d]: got %h want %h", 8 + i, d, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d;
    logic       v;
    logic [3:0] got;
    logic [3:0] adr [3];
    adr = '{4'h2, 4'h3, 4'h5};
    cpu_read(4'h5, d, v);  // leaves RD non-zero
    load_start = 1'b1; load_base = 4'h2;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h44;
    step();
    load_data = 8'h55;
    step();
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    got = {busy, load_ready, load_done, rd_valid};
    total++;
    if (got !== 4'b1000 || RD !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_load: got flags=%b RD=%h want 1000 RD=00", got, RD);
    end
    #2;
    rst = 1'b1;
    count_clear("reclear_len");
    for (int i = 0; i < 3; i++) begin
      cpu_read(adr[i], d, v);
      total++;
      if (d !== 8'h00) begin
        bad++;
        $display("FAIL reclear_mem[%h]: got %h want 00", adr[i], d);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    addr = '0; WD = '0; memorywrite = 1'b0; memoryread = 1'b0;
    load_start = 1'b0; load_base = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    test_reset();
    test_clear_reads();
    test_write_read();
    test_read_first();
    test_load_wrap();
    test_load_stall();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
